// File: rtl/rubiks_polibot_pkg.sv
// Shared definitions for the Rubik's PoliBot control unit.
// - E_W             : width of the state encoding exported on db_estado
// - TIMEOUT_DEFAULT : watchdog limit in clocks (5 s at 50 MHz)
// - S_*             : state encodings 0..23
// - uc_out_t        : bundle of every control output decoded from the state
package rubiks_polibot_pkg;

  localparam int unsigned E_W             = 5;
  localparam int unsigned TIMEOUT_DEFAULT = 250_000_000;

  localparam logic [E_W-1:0] S_INICIAL       = 5'd0;
  localparam logic [E_W-1:0] S_PREPARA       = 5'd1;
  localparam logic [E_W-1:0] S_CAPTURA       = 5'd2;
  localparam logic [E_W-1:0] S_ESPERA_IMAGEM = 5'd3;
  localparam logic [E_W-1:0] S_IDENTIFICA    = 5'd4;
  localparam logic [E_W-1:0] S_ESPERA_CORES  = 5'd5;
  localparam logic [E_W-1:0] S_ENVIA         = 5'd6;
  localparam logic [E_W-1:0] S_ESPERA_ENVIO  = 5'd7;
  localparam logic [E_W-1:0] S_VERIFICA_FACE = 5'd8;
  localparam logic [E_W-1:0] S_CONTA_FACE    = 5'd9;
  localparam logic [E_W-1:0] S_GIRO          = 5'd10;
  localparam logic [E_W-1:0] S_ESPERA_GIRO   = 5'd11;
  localparam logic [E_W-1:0] S_CONTA_GIRO    = 5'd12;
  localparam logic [E_W-1:0] S_DECIDE_GIRO   = 5'd13;
  localparam logic [E_W-1:0] S_OBTER         = 5'd14;
  localparam logic [E_W-1:0] S_ESPERA_MOV    = 5'd15;
  localparam logic [E_W-1:0] S_ZERA_RES      = 5'd16;
  localparam logic [E_W-1:0] S_LE_ROM        = 5'd17;
  localparam logic [E_W-1:0] S_VERIFICA_ROM  = 5'd18;
  localparam logic [E_W-1:0] S_EXECUTA       = 5'd19;
  localparam logic [E_W-1:0] S_ESPERA_EXEC   = 5'd20;
  localparam logic [E_W-1:0] S_CONTA_EXEC    = 5'd21;
  localparam logic [E_W-1:0] S_FIM           = 5'd22;
  localparam logic [E_W-1:0] S_ERRO          = 5'd23;

  typedef struct packed {
    logic zera_face;
    logic zera_movimento;
    logic conta_face;
    logic r_conta_movimento;
    logic captura_imagem;
    logic identificar_cores;
    logic enviar_cores;
    logic obter_movimentos;
    logic aciona_movimento;
    logic sel_serial1;
    logic sel_serial2;
    logic sel_ram_pixel;
    logic sel_cor;
    logic sel_movimento;
    logic pronto;
    logic db_erro;
  } uc_out_t;

  // States that wait on a datapath done pulse and are guarded by the watchdog.
  function automatic logic is_espera(input logic [E_W-1:0] s);
    return (s == S_ESPERA_IMAGEM) || (s == S_ESPERA_CORES) || (s == S_ESPERA_ENVIO) ||
           (s == S_ESPERA_GIRO)   || (s == S_ESPERA_MOV)   || (s == S_ESPERA_EXEC);
  endfunction

endpackage

// File: rtl/rubiks_polibot_uc_watchdog.sv
// Wait-state watchdog (uc_watchdog) for the control unit.
// - clock, reset : system clock, async active-high reset
// - clear        : zero the counter (state changed)
// - enable       : count this cycle (FSM is in a wait state)
// - expired_c    : combinational, high on the LIMIT-th enabled cycle; LIMIT=0 never expires
module rubiks_polibot_uc_watchdog #(
  parameter int unsigned LIMIT = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last   = (LIMIT != 0) && (count == LAST);
  assign expired_c = enable && at_last;

  // Count stops at the last value; the FSM leaves the state on that cycle anyway.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_last && (LIMIT != 0)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rubiks_polibot_uc.sv
// Control unit sequencing the PoliBot datapath through a full solve:
// scan six faces, fetch the solution, execute the movement list.
// Inputs : clock, reset (async, active-high), iniciar, datapath done pulses
//          (imagem_recebida, cores_identificadas, cores_transmitidas,
//          movimentos_recebidos, fim_movimento) and status flags
//          (fim_face, meio_face, movimento_par, fim_rom).
// Outputs: counter controls, sub-block start pulses, mux selects,
//          pronto (FIM), db_erro (ERRO), db_estado (current state).
// Outputs are registered from the next-state decode so they track the state
// register cycle for cycle and clear together with it on reset.
module rubiks_polibot_uc
  import rubiks_polibot_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           iniciar,
  input  logic           imagem_recebida,
  input  logic           cores_identificadas,
  input  logic           cores_transmitidas,
  input  logic           movimentos_recebidos,
  input  logic           fim_movimento,
  input  logic           fim_face,
  input  logic           meio_face,
  input  logic           movimento_par,
  input  logic           fim_rom,
  output logic           zera_face,
  output logic           zera_movimento,
  output logic           conta_face,
  output logic           r_conta_movimento,
  output logic           captura_imagem,
  output logic           identificar_cores,
  output logic           enviar_cores,
  output logic           obter_movimentos,
  output logic           aciona_movimento,
  output logic           sel_serial1,
  output logic           sel_serial2,
  output logic           sel_ram_pixel,
  output logic           sel_cor,
  output logic           sel_movimento,
  output logic           pronto,
  output logic           db_erro,
  output logic [E_W-1:0] db_estado
);

  logic [E_W-1:0] state, state_next;
  uc_out_t        out_next, out_q;
  logic           wd_expired;

  rubiks_polibot_uc_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear     (state_next != state),
    .enable    (is_espera(state)),
    .expired_c (wd_expired)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_INICIAL;
      out_q <= '0;
    end else begin
      state <= state_next;
      out_q <= out_next;
    end
  end

  // Next-state logic; in wait states a done pulse wins over watchdog expiry.
  always_comb begin
    state_next = state;
    case (state)
      S_INICIAL:       if (iniciar) state_next = S_PREPARA;
      S_PREPARA:       state_next = S_CAPTURA;
      S_CAPTURA:       state_next = S_ESPERA_IMAGEM;
      S_ESPERA_IMAGEM: if (imagem_recebida)      state_next = S_IDENTIFICA;
                       else if (wd_expired)      state_next = S_ERRO;
      S_IDENTIFICA:    state_next = S_ESPERA_CORES;
      S_ESPERA_CORES:  if (cores_identificadas)  state_next = S_ENVIA;
                       else if (wd_expired)      state_next = S_ERRO;
      S_ENVIA:         state_next = S_ESPERA_ENVIO;
      S_ESPERA_ENVIO:  if (cores_transmitidas)   state_next = S_VERIFICA_FACE;
                       else if (wd_expired)      state_next = S_ERRO;
      S_VERIFICA_FACE: state_next = fim_face ? S_OBTER : S_CONTA_FACE;
      S_CONTA_FACE:    state_next = S_GIRO;
      S_GIRO:          state_next = S_ESPERA_GIRO;
      S_ESPERA_GIRO:   if (fim_movimento)        state_next = S_CONTA_GIRO;
                       else if (wd_expired)      state_next = S_ERRO;
      S_CONTA_GIRO:    state_next = S_DECIDE_GIRO;
      // Upper faces need a double turn; the address parity tells which half we are on.
      S_DECIDE_GIRO:   state_next = (meio_face && !movimento_par) ? S_GIRO : S_CAPTURA;
      S_OBTER:         state_next = S_ESPERA_MOV;
      S_ESPERA_MOV:    if (movimentos_recebidos) state_next = S_ZERA_RES;
                       else if (wd_expired)      state_next = S_ERRO;
      S_ZERA_RES:      state_next = S_LE_ROM;
      S_LE_ROM:        state_next = S_VERIFICA_ROM;
      S_VERIFICA_ROM:  state_next = fim_rom ? S_FIM : S_EXECUTA;
      S_EXECUTA:       state_next = S_ESPERA_EXEC;
      S_ESPERA_EXEC:   if (fim_movimento)        state_next = S_CONTA_EXEC;
                       else if (wd_expired)      state_next = S_ERRO;
      S_CONTA_EXEC:    state_next = S_LE_ROM;
      S_FIM:           if (iniciar) state_next = S_PREPARA;
      S_ERRO:          if (iniciar) state_next = S_PREPARA;
      default:         state_next = S_INICIAL;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    out_next = '0;
    case (state_next)
      S_PREPARA: begin
        out_next.zera_face      = 1'b1;
        out_next.zera_movimento = 1'b1;
      end
      S_CAPTURA: begin
        out_next.captura_imagem = 1'b1;
        out_next.sel_ram_pixel  = 1'b1;
      end
      S_ESPERA_IMAGEM: out_next.sel_ram_pixel = 1'b1;
      S_IDENTIFICA: begin
        out_next.identificar_cores = 1'b1;
        out_next.sel_cor           = 1'b1;
      end
      S_ESPERA_CORES: out_next.sel_cor = 1'b1;
      S_ENVIA: begin
        out_next.enviar_cores = 1'b1;
        out_next.sel_serial1  = 1'b1;
      end
      S_ESPERA_ENVIO: out_next.sel_serial1       = 1'b1;
      S_CONTA_FACE:   out_next.conta_face        = 1'b1;
      S_GIRO:         out_next.aciona_movimento  = 1'b1;
      S_CONTA_GIRO:   out_next.r_conta_movimento = 1'b1;
      S_OBTER: begin
        out_next.obter_movimentos = 1'b1;
        out_next.sel_movimento    = 1'b1;
        out_next.sel_serial1      = 1'b1;
        out_next.sel_serial2      = 1'b1;
      end
      S_ESPERA_MOV: begin
        out_next.sel_movimento = 1'b1;
        out_next.sel_serial1   = 1'b1;
        out_next.sel_serial2   = 1'b1;
      end
      S_ZERA_RES:   out_next.zera_movimento    = 1'b1;
      S_EXECUTA:    out_next.aciona_movimento  = 1'b1;
      S_CONTA_EXEC: out_next.r_conta_movimento = 1'b1;
      S_FIM:        out_next.pronto            = 1'b1;
      S_ERRO:       out_next.db_erro           = 1'b1;
      default:      out_next = '0;
    endcase
  end

  assign zera_face         = out_q.zera_face;
  assign zera_movimento    = out_q.zera_movimento;
  assign conta_face        = out_q.conta_face;
  assign r_conta_movimento = out_q.r_conta_movimento;
  assign captura_imagem    = out_q.captura_imagem;
  assign identificar_cores = out_q.identificar_cores;
  assign enviar_cores      = out_q.enviar_cores;
  assign obter_movimentos  = out_q.obter_movimentos;
  assign aciona_movimento  = out_q.aciona_movimento;
  assign sel_serial1       = out_q.sel_serial1;
  assign sel_serial2       = out_q.sel_serial2;
  assign sel_ram_pixel     = out_q.sel_ram_pixel;
  assign sel_cor           = out_q.sel_cor;
  assign sel_movimento     = out_q.sel_movimento;
  assign pronto            = out_q.pronto;
  assign db_erro           = out_q.db_erro;
  assign db_estado         = state;

endmodule

// File: tb/tb_rubiks_polibot_uc.sv
// Bench for rubiks_polibot_uc: a small datapath model (face/movement counters,
// delayed done-pulse responders) drives the FSM through directed scenarios.
module tb_rubiks_polibot_uc;

  localparam int DELAY = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic imagem_recebida, cores_identificadas, cores_transmitidas, movimentos_recebidos, fim_movimento;
  logic fim_face, meio_face, movimento_par, fim_rom;
  logic zera_face, zera_movimento, conta_face, r_conta_movimento;
  logic captura_imagem, identificar_cores, enviar_cores, obter_movimentos, aciona_movimento;
  logic sel_serial1, sel_serial2, sel_ram_pixel, sel_cor, sel_movimento, pronto, db_erro;
  logic [4:0] db_estado;

  always #5 clock = ~clock;

  rubiks_polibot_uc #(.TIMEOUT(100)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .imagem_recebida(imagem_recebida), .cores_identificadas(cores_identificadas),
    .cores_transmitidas(cores_transmitidas), .movimentos_recebidos(movimentos_recebidos),
    .fim_movimento(fim_movimento), .fim_face(fim_face), .meio_face(meio_face),
    .movimento_par(movimento_par), .fim_rom(fim_rom),
    .zera_face(zera_face), .zera_movimento(zera_movimento), .conta_face(conta_face),
    .r_conta_movimento(r_conta_movimento), .captura_imagem(captura_imagem),
    .identificar_cores(identificar_cores), .enviar_cores(enviar_cores),
    .obter_movimentos(obter_movimentos), .aciona_movimento(aciona_movimento),
    .sel_serial1(sel_serial1), .sel_serial2(sel_serial2), .sel_ram_pixel(sel_ram_pixel),
    .sel_cor(sel_cor), .sel_movimento(sel_movimento), .pronto(pronto), .db_erro(db_erro),
    .db_estado(db_estado)
  );

  wire [15:0] outs = {zera_face, zera_movimento, conta_face, r_conta_movimento,
                      captura_imagem, identificar_cores, enviar_cores, obter_movimentos,
                      aciona_movimento, sel_serial1, sel_serial2, sel_ram_pixel,
                      sel_cor, sel_movimento, pronto, db_erro};

  // Datapath model: face counter, movement address, end-of-list address.
  int q = 0, addr = 0, rom_end = 5;
  assign fim_face      = (q == 5);
  assign meio_face     = (q >= 3);
  assign movimento_par = ((addr % 2) == 0);
  assign fim_rom       = (addr == rom_end);

  // Done responders: each start pulse answered DELAY clocks later.
  wire  [4:0] start_v = {aciona_movimento, obter_movimentos, enviar_cores, identificar_cores, captura_imagem};
  logic [4:0] done_v = '0;
  int         cnt[5];
  logic       respond_en = 1'b1;
  logic       man_img = 1'b0, man_mov = 1'b0;
  assign imagem_recebida      = done_v[0] | man_img;
  assign cores_identificadas  = done_v[1];
  assign cores_transmitidas   = done_v[2];
  assign movimentos_recebidos = done_v[3];
  assign fim_movimento        = done_v[4] | man_mov;

  always @(negedge clock) begin
    for (int i = 0; i < 5; i++) begin
      if (reset) begin
        cnt[i]    <= 0;
        done_v[i] <= 1'b0;
      end else begin
        done_v[i] <= 1'b0;
        if (cnt[i] > 1) cnt[i] <= cnt[i] - 1;
        else if (cnt[i] == 1) begin
          cnt[i]    <= 0;
          done_v[i] <= respond_en;
        end else if (start_v[i]) cnt[i] <= DELAY;
      end
    end
  end

  // Counter model and event tallies, sampled on the active edge like the datapath.
  logic clr_cnt = 1'b0;
  int   n_cap = 0, n_cf = 0, n_exec = 0, n_giro = 0;
  int   giro_by_q[8];
  logic in_exec = 1'b0;

  always @(posedge clock) begin
    if (zera_face) q <= 0; else if (conta_face) q <= q + 1;
    if (zera_movimento) addr <= 0; else if (r_conta_movimento) addr <= addr + 1;
    if (clr_cnt) begin
      n_cap <= 0; n_cf <= 0; n_exec <= 0; n_giro <= 0; in_exec <= 1'b0;
      for (int i = 0; i < 8; i++) giro_by_q[i] <= 0;
    end else begin
      if (captura_imagem) n_cap <= n_cap + 1;
      if (conta_face) n_cf <= n_cf + 1;
      if (obter_movimentos) in_exec <= 1'b1;
      if (aciona_movimento) begin
        if (in_exec) n_exec <= n_exec + 1;
        else begin
          n_giro <= n_giro + 1;
          giro_by_q[q % 8] <= giro_by_q[q % 8] + 1;
        end
      end
    end
  end

  // Select / status decode monitor against the state table.
  int   sel_viol = 0;
  logic seen_s10 = 1'b0, seen_s11 = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (sel_ram_pixel != (db_estado == 2 || db_estado == 3) ||
          sel_cor       != (db_estado == 4 || db_estado == 5) ||
          sel_serial1   != (db_estado inside {6, 7, 14, 15}) ||
          sel_serial2   != (db_estado inside {14, 15}) ||
          sel_movimento != (db_estado inside {14, 15}) ||
          pronto        != (db_estado == 22) ||
          db_erro       != (db_estado == 23))
        sel_viol <= sel_viol + 1;
      if (sel_serial1 && !sel_serial2) seen_s10 <= 1'b1;
      if (sel_serial1 && sel_serial2) seen_s11 <= 1'b1;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [4:0] s, input int max, input string tag);
    int i = 0;
    while (db_estado != s && i < max) begin
      @(negedge clock);
      i++;
    end
    check(tag, 32'(db_estado), 32'(s));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clock);
    check("rst_state", 32'(db_estado), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_hold", 32'(db_estado), 32'd0);

    // Full run, list ends at address 5.
    clr_cnt = 1'b1;
    @(negedge clock);
    clr_cnt = 1'b0;
    pulse_iniciar();
    check("prepara", 32'(db_estado), 32'd1);
    check("prepara_zera", 32'({zera_face, zera_movimento}), 32'd3);
    wait_state(5'd22, 5000, "full_fim");
    check("full_captures", 32'(n_cap), 32'd6);
    check("full_conta_face", 32'(n_cf), 32'd5);
    check("full_exec_moves", 32'(n_exec), 32'd5);
    check("scan_giros", 32'(n_giro), 32'd8);
    check("giro_face1", 32'(giro_by_q[1]), 32'd1);
    check("giro_face2", 32'(giro_by_q[2]), 32'd1);
    check("giro_face3", 32'(giro_by_q[3]), 32'd2);
    check("giro_face5", 32'(giro_by_q[5]), 32'd2);
    check("full_pronto", 32'(pronto), 32'd1);
    check("full_erro", 32'(db_erro), 32'd0);

    // iniciar held in FIM restarts and re-zeroes; empty list this time.
    rom_end = 0;
    iniciar = 1'b1;
    clr_cnt = 1'b1;
    @(negedge clock);
    clr_cnt = 1'b0;
    check("restart_prepara", 32'(db_estado), 32'd1);
    @(negedge clock);
    iniciar = 1'b0;
    check("restart_captura", 32'(db_estado), 32'd2);
    check("restart_q_zero", 32'(q), 32'd0);
    check("restart_addr_zero", 32'(addr), 32'd0);
    wait_state(5'd22, 5000, "empty_fim");
    check("empty_exec_moves", 32'(n_exec), 32'd0);
    check("empty_captures", 32'(n_cap), 32'd6);

    // Watchdog: withhold imagem_recebida.
    do_reset();
    respond_en = 1'b0;
    pulse_iniciar();
    wait_state(5'd3, 20, "wd_enter");
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clock);
      if (db_estado != 5'd3) break;
      cyc++;
    end
    check("wd_cycles", 32'(cyc), 32'd100);
    check("wd_erro_state", 32'(db_estado), 32'd23);
    repeat (3) @(negedge clock);
    check("wd_erro_hold", 32'(db_estado), 32'd23);
    check("wd_db_erro", 32'(db_erro), 32'd1);
    pulse_iniciar();
    check("erro_restart", 32'(db_estado), 32'd1);
    wait_state(5'd3, 20, "wd_reenter");
    repeat (99) @(negedge clock);
    check("wd_last_cycle", 32'(db_estado), 32'd3);
    man_img = 1'b1;
    @(negedge clock);
    man_img = 1'b0;
    check("wd_late_pulse", 32'(db_estado), 32'd4);

    // Async reset while a movement is executing.
    do_reset();
    respond_en = 1'b1;
    rom_end = 5;
    pulse_iniciar();
    wait_state(5'd20, 5000, "exec_reach");
    #2 reset = 1'b1;
    #1;
    check("midrst_state", 32'(db_estado), 32'd0);
    check("midrst_outs", 32'(outs), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    man_mov = 1'b1;
    @(negedge clock);
    man_mov = 1'b0;
    @(negedge clock);
    check("stray_ignored", 32'(db_estado), 32'd0);
    check("stray_outs", 32'(outs), 32'd0);

    check("sel_decode", 32'(sel_viol), 32'd0);
    check("sel_s1_only_seen", 32'(seen_s10), 32'd1);
    check("sel_s1_s2_seen", 32'(seen_s11), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
